// File: rtl/superscalar_pkg.sv
// Shared widths, global tag map, opcodes and reservation-station
// entry state encoding for the dispatch/issue slice.
package superscalar_pkg;

  localparam int TAG_LEN  = 4;
  localparam int DATA_WID = 16;
  localparam int OP_WID   = 4;

  // Global RS tags; 0 means "no producer, value present"
  localparam logic [TAG_LEN-1:0] NO_TAG = 4'd0;
  localparam logic [TAG_LEN-1:0] ADD_0  = 4'd1;
  localparam logic [TAG_LEN-1:0] ADD_1  = 4'd2;
  localparam logic [TAG_LEN-1:0] MULT_0 = 4'd3;
  localparam logic [TAG_LEN-1:0] MULT_1 = 4'd4;
  localparam logic [TAG_LEN-1:0] LOAD_0 = 4'd5;
  localparam logic [TAG_LEN-1:0] LOAD_1 = 4'd6;

  localparam logic [OP_WID-1:0] OP_ADD   = 4'd1;
  localparam logic [OP_WID-1:0] OP_MULT  = 4'd2;
  localparam logic [OP_WID-1:0] OP_LOAD  = 4'd3;
  localparam logic [OP_WID-1:0] OP_STORE = 4'd4;

  // Entry state encoding
  localparam logic [1:0] ST_FREE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_EXEC  = 2'd3;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: state machine, operand capture
// with same-cycle CDB forwarding, and CDB snoop while waiting.
module rs_entry #(
  parameter int TAG_LEN  = superscalar_pkg::TAG_LEN,
  parameter int DATA_WID = superscalar_pkg::DATA_WID,
  parameter int OP_WID   = superscalar_pkg::OP_WID,
  parameter int MY_TAG   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [OP_WID-1:0]   ld_op,
  input  logic [TAG_LEN-1:0]  ld_s0_tag,
  input  logic [DATA_WID-1:0] ld_s0_val,
  input  logic [TAG_LEN-1:0]  ld_s1_tag,
  input  logic [DATA_WID-1:0] ld_s1_val,
  input  logic                cdb_valid,
  input  logic [TAG_LEN-1:0]  cdb_tag,
  input  logic [DATA_WID-1:0] cdb_data,
  input  logic                issue,
  output logic [1:0]          state,
  output logic                freeing,
  output logic [OP_WID-1:0]   op,
  output logic [DATA_WID-1:0] a,
  output logic [DATA_WID-1:0] b
);
  import superscalar_pkg::*;

  localparam logic [TAG_LEN-1:0] OWN = TAG_LEN'(MY_TAG);

  logic [TAG_LEN-1:0] t0, t1;
  logic cdb_hit, fw0, fw1, sn0, sn1;

  assign cdb_hit = cdb_valid && (cdb_tag != '0);
  assign fw0 = cdb_hit && (ld_s0_tag == cdb_tag);
  assign fw1 = cdb_hit && (ld_s1_tag == cdb_tag);
  assign sn0 = cdb_hit && (t0 == cdb_tag);
  assign sn1 = cdb_hit && (t1 == cdb_tag);

  // Own-tag broadcast only matters once the op is executing
  assign freeing = (state == ST_EXEC) && cdb_valid
                   && (cdb_tag == OWN);

  // Entry lifecycle and operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FREE;
      op    <= '0;
      t0    <= '0;
      t1    <= '0;
      a     <= '0;
      b     <= '0;
    end else begin
      unique case (state)
        ST_FREE: begin
          if (load) begin
            state <= ST_WAIT;
            op    <= ld_op;
            t0    <= fw0 ? '0 : ld_s0_tag;
            a     <= fw0 ? cdb_data : ld_s0_val;
            t1    <= fw1 ? '0 : ld_s1_tag;
            b     <= fw1 ? cdb_data : ld_s1_val;
          end
        end
        ST_WAIT: begin
          if (t0 == '0 && t1 == '0) state <= ST_READY;
          if (sn0) begin
            t0 <= '0;
            a  <= cdb_data;
          end
          if (sn1) begin
            t1 <= '0;
            b  <= cdb_data;
          end
        end
        ST_READY: begin
          if (issue) state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (freeing) state <= ST_FREE;
        end
        default: state <= ST_FREE;
      endcase
    end
  end

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: two dispatch buses in, oldest-ready issue out.
// Optional macro RS_DISP_CHECK_EN enables the registered disp_err pulse.
module rs_bank #(
  parameter int NUM_ENT  = 2,
  parameter int BASE_TAG = 1,
  parameter int TAG_LEN  = superscalar_pkg::TAG_LEN,
  parameter int DATA_WID = superscalar_pkg::DATA_WID,
  parameter int OP_WID   = superscalar_pkg::OP_WID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d1_valid,
  input  logic [TAG_LEN-1:0]  d1_rs_tag,
  input  logic [OP_WID-1:0]   d1_op,
  input  logic [TAG_LEN-1:0]  d1_s0_tag,
  input  logic [TAG_LEN-1:0]  d1_s1_tag,
  input  logic [DATA_WID-1:0] d1_s0_val,
  input  logic [DATA_WID-1:0] d1_s1_val,
  input  logic                d2_valid,
  input  logic [TAG_LEN-1:0]  d2_rs_tag,
  input  logic [OP_WID-1:0]   d2_op,
  input  logic [TAG_LEN-1:0]  d2_s0_tag,
  input  logic [TAG_LEN-1:0]  d2_s1_tag,
  input  logic [DATA_WID-1:0] d2_s0_val,
  input  logic [DATA_WID-1:0] d2_s1_val,
  input  logic                cdb_valid,
  input  logic [TAG_LEN-1:0]  cdb_tag,
  input  logic [DATA_WID-1:0] cdb_data,
  output logic                iss_valid,
  input  logic                iss_ready,
  output logic [TAG_LEN-1:0]  iss_tag,
  output logic [OP_WID-1:0]   iss_op,
  output logic [DATA_WID-1:0] iss_a,
  output logic [DATA_WID-1:0] iss_b,
  output logic [NUM_ENT-1:0]  busy,
  output logic                disp_err
);
  import superscalar_pkg::*;

  localparam int IW = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
  localparam int RW = 3;

  logic [1:0]          st    [NUM_ENT];
  logic [OP_WID-1:0]   e_op  [NUM_ENT];
  logic [DATA_WID-1:0] e_a   [NUM_ENT];
  logic [DATA_WID-1:0] e_b   [NUM_ENT];
  logic [RW-1:0]       rank  [NUM_ENT];
  logic [RW-1:0]       rank_n[NUM_ENT];

  logic [NUM_ENT-1:0] tgt1, tgt2, free, ld1, ld2;
  logic [NUM_ENT-1:0] rdy, issue, freeing;
  logic ok1, ok2;
  logic [RW-1:0] stay_cnt, dec;
  logic [IW-1:0] pick, hold_idx;
  logic found, hold;

  // Decode bus targets; bus 1 wins a same-entry collision
  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      tgt1[i] = d1_valid && (d1_rs_tag == TAG_LEN'(BASE_TAG + i));
      tgt2[i] = d2_valid && (d2_rs_tag == TAG_LEN'(BASE_TAG + i));
      free[i] = (st[i] == ST_FREE);
      rdy[i]  = (st[i] == ST_READY);
      busy[i] = !free[i];
    end
`ifdef RS_DISP_CHECK_EN
    ok1 = (d1_s0_tag != d1_rs_tag) && (d1_s1_tag != d1_rs_tag);
    ok2 = (d2_s0_tag != d2_rs_tag) && (d2_s1_tag != d2_rs_tag);
`else
    ok1 = 1'b1;
    ok2 = 1'b1;
`endif
    ld1 = tgt1 & free & {NUM_ENT{ok1}};
    ld2 = tgt2 & free & ~tgt1 & {NUM_ENT{ok2}};
  end

`ifdef RS_DISP_CHECK_EN
  logic err_n;

  // Flag busy target, bus collision or self-dependent source
  always_comb begin
    err_n = 1'b0;
    if (|tgt1 && (!(|(tgt1 & free)) || !ok1)) err_n = 1'b1;
    if (|tgt2 && (!(|(tgt2 & free)) || !ok2 || |(tgt1 & tgt2)))
      err_n = 1'b1;
  end

  // Registered one-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp_err <= 1'b0;
    else     disp_err <= err_n;
  end
`else
  assign disp_err = 1'b0;
`endif

  genvar g;
  generate
    for (g = 0; g < NUM_ENT; g++) begin : g_ent
      rs_entry #(
        .TAG_LEN (TAG_LEN),
        .DATA_WID(DATA_WID),
        .OP_WID  (OP_WID),
        .MY_TAG  (BASE_TAG + g)
      ) u_ent (
        .clk      (clk),
        .rst      (rst),
        .load     (ld1[g] | ld2[g]),
        .ld_op    (ld1[g] ? d1_op     : d2_op),
        .ld_s0_tag(ld1[g] ? d1_s0_tag : d2_s0_tag),
        .ld_s0_val(ld1[g] ? d1_s0_val : d2_s0_val),
        .ld_s1_tag(ld1[g] ? d1_s1_tag : d2_s1_tag),
        .ld_s1_val(ld1[g] ? d1_s1_val : d2_s1_val),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .issue    (issue[g]),
        .state    (st[g]),
        .freeing  (freeing[g]),
        .op       (e_op[g]),
        .a        (e_a[g]),
        .b        (e_b[g])
      );
    end
  endgenerate

  // Age rank: 0 is oldest; ranks compact as older entries free
  always_comb begin
    stay_cnt = '0;
    dec      = '0;
    for (int i = 0; i < NUM_ENT; i++)
      if (!free[i] && !freeing[i]) stay_cnt = stay_cnt + 1'b1;
    for (int i = 0; i < NUM_ENT; i++) begin
      rank_n[i] = rank[i];
      if (!free[i]) begin
        dec = '0;
        for (int j = 0; j < NUM_ENT; j++)
          if (freeing[j] && rank[j] < rank[i]) dec = dec + 1'b1;
        rank_n[i] = rank[i] - dec;
      end else if (ld1[i]) begin
        rank_n[i] = stay_cnt;
      end else if (ld2[i]) begin
        rank_n[i] = stay_cnt + RW'(|ld1);
      end
    end
  end

  // Age rank registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) rank[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) rank[i] <= rank_n[i];
    end
  end

  // Oldest ready entry, unless an offer is already pending
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_ENT; i++)
      if (rdy[i] && (!found || rank[i] < rank[pick])) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    if (hold) begin
      pick  = hold_idx;
      found = 1'b1;
    end
    for (int i = 0; i < NUM_ENT; i++)
      issue[i] = found && iss_ready && (pick == IW'(i));
  end

  assign iss_valid = found;
  assign iss_tag = found ? TAG_LEN'(BASE_TAG) + TAG_LEN'(pick) : '0;
  assign iss_op  = found ? e_op[pick] : '0;
  assign iss_a   = found ? e_a[pick]  : '0;
  assign iss_b   = found ? e_b[pick]  : '0;

  // Lock the offered entry until the FU takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= 1'b0;
      hold_idx <= '0;
    end else begin
      hold     <= found && !iss_ready;
      hold_idx <= pick;
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Scoreboard bench for rs_bank (BASE_TAG=1, NUM_ENT=2).
// Works with and without RS_DISP_CHECK_EN defined.
module tb_rs_bank;

  logic clk = 0;
  logic rst;
  logic d1_valid, d2_valid;
  logic [3:0] d1_rs_tag, d1_op, d1_s0_tag, d1_s1_tag;
  logic [3:0] d2_rs_tag, d2_op, d2_s0_tag, d2_s1_tag;
  logic [15:0] d1_s0_val, d1_s1_val, d2_s0_val, d2_s1_val;
  logic cdb_valid;
  logic [3:0] cdb_tag;
  logic [15:0] cdb_data;
  logic iss_valid, iss_ready;
  logic [3:0] iss_tag, iss_op;
  logic [15:0] iss_a, iss_b;
  logic [1:0] busy;
  logic disp_err;

  typedef struct {
    logic [3:0]  tag;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef RS_DISP_CHECK_EN
  logic err_exp = 1'b1;
`else
  logic err_exp = 1'b0;
`endif

  rs_bank #(.NUM_ENT(2), .BASE_TAG(1)) dut (
    .clk(clk), .rst(rst),
    .d1_valid(d1_valid), .d1_rs_tag(d1_rs_tag), .d1_op(d1_op),
    .d1_s0_tag(d1_s0_tag), .d1_s1_tag(d1_s1_tag),
    .d1_s0_val(d1_s0_val), .d1_s1_val(d1_s1_val),
    .d2_valid(d2_valid), .d2_rs_tag(d2_rs_tag), .d2_op(d2_op),
    .d2_s0_tag(d2_s0_tag), .d2_s1_tag(d2_s1_tag),
    .d2_s0_val(d2_s0_val), .d2_s1_val(d2_s1_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_tag(iss_tag), .iss_op(iss_op),
    .iss_a(iss_a), .iss_b(iss_b),
    .busy(busy), .disp_err(disp_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handshake pops the next expected issue
  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL issue_unexpected: got tag=%0d, required none",
                 iss_tag);
      end else begin
        e = sb.pop_front();
        if (iss_tag !== e.tag || iss_op !== e.op ||
            iss_a !== e.a || iss_b !== e.b) begin
          n_bad++;
          $display("FAIL issue_payload: got %0d/%0d/%h/%h required %0d/%0d/%h/%h",
                   iss_tag, iss_op, iss_a, iss_b, e.tag, e.op, e.a, e.b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d1_valid = 0; d1_rs_tag = 0; d1_op = 0;
    d1_s0_tag = 0; d1_s1_tag = 0; d1_s0_val = 0; d1_s1_val = 0;
    d2_valid = 0; d2_rs_tag = 0; d2_op = 0;
    d2_s0_tag = 0; d2_s1_tag = 0; d2_s0_val = 0; d2_s1_val = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic disp1(input logic [3:0] t, input logic [3:0] o,
                       input logic [3:0] t0, input logic [15:0] v0,
                       input logic [3:0] t1, input logic [15:0] v1);
    d1_valid = 1; d1_rs_tag = t; d1_op = o;
    d1_s0_tag = t0; d1_s0_val = v0; d1_s1_tag = t1; d1_s1_val = v1;
  endtask

  task automatic disp2(input logic [3:0] t, input logic [3:0] o,
                       input logic [3:0] t0, input logic [15:0] v0,
                       input logic [3:0] t1, input logic [15:0] v1);
    d2_valid = 1; d2_rs_tag = t; d2_op = o;
    d2_s0_tag = t0; d2_s0_val = v0; d2_s1_tag = t1; d2_s1_val = v1;
  endtask

  task automatic push(input logic [3:0] t, input logic [3:0] o,
                      input logic [15:0] a, input logic [15:0] b);
    exp_t x;
    x.tag = t; x.op = o; x.a = a; x.b = b;
    sb.push_back(x);
  endtask

  // Raise iss_ready and wait (bounded) for one handshake
  task automatic accept();
    int n = 0;
    iss_ready = 1;
    while (!iss_valid && n < 20) begin
      step();
      n++;
    end
    n_cmp++;
    if (!iss_valid) begin
      n_bad++;
      $display("FAIL accept_timeout: iss_valid=0 required 1");
    end
    step();
    iss_ready = 0;
  endtask

  task automatic cdb_done(input logic [3:0] t);
    cdb_valid = 1; cdb_tag = t; cdb_data = 16'hDEAD;
    step();
    cdb_valid = 0; cdb_tag = 0;
  endtask

  task automatic test_reset();
    rst = 1; iss_ready = 0; idle();
    #12;
    n_cmp++;
    if (busy !== 2'b00 || iss_valid !== 0 || disp_err !== 0 ||
        iss_tag !== 0 || iss_op !== 0 || iss_a !== 0 || iss_b !== 0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b iss_valid=%b err=%b required 00/0/0",
               busy, iss_valid, disp_err);
    end
    step();
    rst = 0;
    step();
  endtask

  task automatic test_basic();
    disp1(4'd1, 4'd1, 4'd0, 16'd3, 4'd0, 16'd4);
    push(4'd1, 4'd1, 16'd3, 16'd4);
    step();
    idle();
    n_cmp++;
    if (busy !== 2'b01 || iss_valid !== 0) begin
      n_bad++;
      $display("FAIL basic_busy: busy=%b iss_valid=%b required 01/0",
               busy, iss_valid);
    end
    step();
    n_cmp++;
    if (iss_valid !== 1 || iss_tag !== 4'd1) begin
      n_bad++;
      $display("FAIL basic_latency: iss_valid=%b tag=%0d required 1/1",
               iss_valid, iss_tag);
    end
    accept();
    n_cmp++;
    if (busy !== 2'b01 || iss_valid !== 0) begin
      n_bad++;
      $display("FAIL basic_exec: busy=%b iss_valid=%b required 01/0",
               busy, iss_valid);
    end
    cdb_done(4'd1);
    n_cmp++;
    if (busy !== 2'b00) begin
      n_bad++;
      $display("FAIL basic_free: busy=%b required 00", busy);
    end
  endtask

  task automatic test_snoop();
    disp1(4'd2, 4'd2, 4'd5, 16'd0, 4'd0, 16'd7);
    push(4'd2, 4'd2, 16'h00AA, 16'd7);
    step();
    idle();
    step();
    step();
    n_cmp++;
    if (iss_valid !== 0 || busy !== 2'b10) begin
      n_bad++;
      $display("FAIL snoop_wait: iss_valid=%b busy=%b required 0/10",
               iss_valid, busy);
    end
    cdb_valid = 1; cdb_tag = 4'd5; cdb_data = 16'h00AA;
    step();
    idle();
    step();
    n_cmp++;
    if (iss_valid !== 1 || iss_a !== 16'h00AA) begin
      n_bad++;
      $display("FAIL snoop_ready: iss_valid=%b a=%h required 1/00aa",
               iss_valid, iss_a);
    end
    accept();
    cdb_done(4'd2);
    n_cmp++;
    if (busy !== 2'b00) begin
      n_bad++;
      $display("FAIL snoop_free: busy=%b required 00", busy);
    end
  endtask

  task automatic test_forward();
    disp1(4'd1, 4'd1, 4'd0, 16'd1, 4'd6, 16'hFFFF);
    cdb_valid = 1; cdb_tag = 4'd6; cdb_data = 16'h1234;
    push(4'd1, 4'd1, 16'd1, 16'h1234);
    step();
    idle();
    accept();
    cdb_done(4'd1);
  endtask

  task automatic test_age_same_cycle();
    disp1(4'd1, 4'd3, 4'd0, 16'h11, 4'd0, 16'h22);
    disp2(4'd2, 4'd4, 4'd0, 16'h33, 4'd0, 16'h44);
    push(4'd1, 4'd3, 16'h11, 16'h22);
    push(4'd2, 4'd4, 16'h33, 16'h44);
    step();
    idle();
    step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (iss_valid !== 1 || iss_tag !== 4'd1 || iss_a !== 16'h11) begin
        n_bad++;
        $display("FAIL age_hold[%0d]: valid=%b tag=%0d a=%h required 1/1/0011",
                 k, iss_valid, iss_tag, iss_a);
      end
      step();
    end
    accept();
    n_cmp++;
    if (iss_valid !== 1 || iss_tag !== 4'd2) begin
      n_bad++;
      $display("FAIL age_next: valid=%b tag=%0d required 1/2",
               iss_valid, iss_tag);
    end
    accept();
    cdb_done(4'd1);
    cdb_done(4'd2);
  endtask

  task automatic test_no_preempt();
    disp1(4'd1, 4'd1, 4'd5, 16'd0, 4'd0, 16'd2);
    step();
    disp1(4'd2, 4'd2, 4'd0, 16'd8, 4'd0, 16'd9);
    push(4'd2, 4'd2, 16'd8, 16'd9);
    push(4'd1, 4'd1, 16'h55, 16'd2);
    step();
    idle();
    step();
    cdb_valid = 1; cdb_tag = 4'd5; cdb_data = 16'h55;
    step();
    idle();
    step();
    step();
    n_cmp++;
    if (iss_valid !== 1 || iss_tag !== 4'd2) begin
      n_bad++;
      $display("FAIL no_preempt: valid=%b tag=%0d required 1/2",
               iss_valid, iss_tag);
    end
    accept();
    accept();
    cdb_done(4'd2);
    cdb_done(4'd1);
  endtask

  task automatic test_dispatch_rules();
    disp1(4'd3, 4'd1, 4'd0, 16'd1, 4'd0, 16'd1);
    step();
    idle();
    n_cmp++;
    if (busy !== 2'b00 || disp_err !== 0) begin
      n_bad++;
      $display("FAIL out_of_range: busy=%b err=%b required 00/0",
               busy, disp_err);
    end
    disp1(4'd1, 4'd1, 4'd0, 16'd5, 4'd0, 16'd6);
    disp2(4'd1, 4'd2, 4'd0, 16'd9, 4'd0, 16'd9);
    push(4'd1, 4'd1, 16'd5, 16'd6);
    step();
    idle();
    n_cmp++;
    if (busy !== 2'b01 || disp_err !== err_exp) begin
      n_bad++;
      $display("FAIL collision: busy=%b err=%b required 01/%b",
               busy, disp_err, err_exp);
    end
    step();
    n_cmp++;
    if (disp_err !== 0) begin
      n_bad++;
      $display("FAIL err_pulse: err=%b required 0", disp_err);
    end
    disp1(4'd1, 4'd2, 4'd0, 16'h77, 4'd0, 16'h77);
    step();
    idle();
    n_cmp++;
    if (disp_err !== err_exp) begin
      n_bad++;
      $display("FAIL busy_target: err=%b required %b", disp_err, err_exp);
    end
    accept();
    cdb_done(4'd1);
`ifdef RS_DISP_CHECK_EN
    disp1(4'd2, 4'd1, 4'd2, 16'd0, 4'd0, 16'd0);
    step();
    idle();
    n_cmp++;
    if (disp_err !== 1 || busy !== 2'b00) begin
      n_bad++;
      $display("FAIL self_tag: err=%b busy=%b required 1/00",
               disp_err, busy);
    end
    step();
`endif
  endtask

  task automatic test_reset_exec();
    disp1(4'd1, 4'd1, 4'd0, 16'd1, 4'd0, 16'd2);
    disp2(4'd2, 4'd1, 4'd5, 16'd0, 4'd0, 16'd2);
    push(4'd1, 4'd1, 16'd1, 16'd2);
    step();
    idle();
    accept();
    #2 rst = 1;
    #1;
    n_cmp++;
    if (busy !== 2'b00 || iss_valid !== 0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b iss_valid=%b required 00/0",
               busy, iss_valid);
    end
    step();
    rst = 0;
    cdb_done(4'd1);
    step();
    n_cmp++;
    if (busy !== 2'b00 || iss_valid !== 0) begin
      n_bad++;
      $display("FAIL post_reset_cdb: busy=%b iss_valid=%b required 00/0",
               busy, iss_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snoop();
    test_forward();
    test_age_same_cycle();
    test_no_preempt();
    test_dispatch_rules();
    test_reset_exec();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Receiving end of the two instruction dispatch buses. A bank of NUM_ENT reservation-station entries for one functional-unit class (ADD, MULT or LOAD/STORE), addressed by a global RS tag.
- Captures dispatched operations and snoops the common data bus (CDB) for pending source tags.
- Issues the oldest ready entry to its functional unit over a valid/ready handshake.
- Reports per-entry busy status back to the dispatcher. An entry is freed when its own tag is broadcast on the CDB.

Parameters:
- NUM_ENT, 2, entries in this bank (1..4).
- BASE_TAG, 1, global tag of entry 0; entry i owns tag BASE_TAG+i; tag 0 means "value valid, no producer".
- TAG_LEN, 4, tag width.
- DATA_WID, 16, operand/result width.
- OP_WID, 4, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- d1_valid  in  1  dispatch bus 1 valid.
- d1_rs_tag  in  TAG_LEN  target entry tag.
- d1_op  in  OP_WID  opcode.
- d1_s0_tag / d1_s1_tag  in  TAG_LEN  source producer tags (0 = value present).
- d1_s0_val / d1_s1_val  in  DATA_WID  source values, used when the tag is 0.
- d2_* (same seven signals as d1_*)  in  dispatch bus 2.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_LEN  producer tag.
- cdb_data  in  DATA_WID  result.
- iss_valid  out  1  operation offered to the FU.
- iss_ready  in  1  FU accepts.
- iss_tag  out  TAG_LEN  issuing entry tag.
- iss_op  out  OP_WID.
- iss_a / iss_b  out  DATA_WID  operands.
- busy  out  NUM_ENT  entry occupied; the dispatcher must not target a busy entry.
- disp_err  out  1  illegal dispatch pulse.

Behaviour:
- Interface (already decided): one clock, clk; rst is asynchronous and active-high.
- Reset: all entries FREE; busy=0, iss_valid=0, iss_tag/op/a/b=0, disp_err=0, age counters cleared.
- Per-entry states:
  - FREE -> WAIT on accepted dispatch.
  - WAIT -> READY when both source tags are 0.
  - READY -> EXEC on an iss_valid&&iss_ready handshake for this entry.
  - EXEC -> FREE on cdb_valid with cdb_tag == own tag.
  - An entry whose sources are ready at dispatch goes FREE -> WAIT, then READY the next cycle. There is no same-cycle issue; minimum dispatch-to-issue latency is 2 cycles.
- Dispatch acceptance:
  - A bus is accepted when valid, BASE_TAG <= rs_tag < BASE_TAG+NUM_ENT, and the target is FREE.
  - A tag outside this bank's range is ignored silently, because other banks share the buses.
  - busy[i] is registered; it goes 1 the cycle after acceptance and 0 the cycle after freeing CDB broadcast.
- CDB snoop: each cycle, every WAIT entry with s*_tag == cdb_tag (cdb_tag != 0) loads cdb_data into s*_val and clears s*_tag.
- CDB forwarding: a dispatched source tag equal to the same-cycle cdb_tag is captured as ready with cdb_data. A broadcast is never missed.
- Issue selection:
  - Among READY entries, the oldest wins. Age is a per-entry dispatch sequence number; bus 1 is older than bus 2 in the same cycle.
  - Ties are impossible; entry index is the fallback.
  - Outputs are combinational from the selected entry.
  - iss_valid, once asserted, holds with stable payload until iss_ready. No retraction; a newly readied older entry does not pre-empt.
- Free and dispatch in the same cycle: an entry freed by the CDB this cycle is still FREE only from the next cycle. Dispatch to it in the same cycle is illegal.
- Own-tag CDB while WAIT/READY: protocol violation; ignored.
- Reset mid-operation: all entries dropped immediately; in-flight FU results are discarded by design above.

Optional Feature:
- Macro RS_DISP_CHECK_EN.
- Defined: disp_err pulses one cycle (registered) when any of the following occurs, and the offending dispatch is dropped:
  - an in-range dispatch targets an entry that is not FREE;
  - both buses target the same entry in one cycle (bus 1 is accepted, bus 2 is dropped);
  - a source tag equals the destination rs_tag.
- Undefined: disp_err tied 0. Same-entry collision still gives bus 1 priority. A dispatch to a non-FREE entry is dropped without indication.

Decomposition:
- Shared package superscalar_pkg holds:
  - TAG_LEN, DATA_WID, OP_WID;
  - global tag constants ADD_0, ADD_1, MULT_0, MULT_1, LOAD_0, LOAD_1 (values 1..6; 0 = no tag);
  - opcodes OP_ADD=1, OP_MULT=2, OP_LOAD=3, OP_STORE=4;
  - the entry state encoding.
- One natural sub-module, rs_entry: a single entry's state machine, operand capture and CDB snoop.
- rs_bank instantiates NUM_ENT of rs_entry plus the age/select logic.

Test Plan (BASE_TAG=1, NUM_ENT=2):
- Reset, then d1 rs_tag=1, op=1, src tags 0, vals 3/4 -> busy=01 next cycle; iss_valid with tag=1, a=3, b=4 two cycles after dispatch; iss_ready=1 -> cdb tag=1 -> busy=00 the following cycle.
- d1 to entry 1 with s0_tag=5, then cdb_valid tag=5 data=0x00AA -> entry becomes READY; issues with a=0x00AA.
- Forwarding: dispatch with s1_tag=6 while cdb_tag=6 data=0x1234 in the same cycle -> issues with b=0x1234, no hang.
- Age ordering: entry 2 dispatched on d2 and entry 1 on d1 in the same cycle, both ready, iss_ready=0 for 3 cycles -> iss_tag=1 is held stable; after acceptance, tag=2 is offered.
- With RS_DISP_CHECK_EN: d1 and d2 both target tag 1 -> bus 1 is accepted and disp_err=1 for one cycle; dispatch to busy entry 1 -> disp_err=1, entry contents unchanged.
- Assert rst while an entry is in EXEC -> busy=0 and iss_valid=0 immediately (asynchronous); a later cdb tag=1 causes no state change.
